mem_stage: RTL and testbench

- Memory stage of the pipelined CPU, directly downstream of the execute stage.
- Latches the execute-stage results (alu_res, write_data, control bits) into an EX/MEM register.
- Runs a variable-latency req/ack access to data memory for loads and stores, stalling upstream while the access is outstanding.
- Produces the MEM/WB register contents and the forwarding value consumed by the execute stage (fwd_res).

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_dmem_if.sv | 71 +++++++
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory stage: datapath widths,
// the data-memory access FSM states and the EX/MEM latch layout.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int REG_W  = 5;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } dmem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] write_data;
    logic              is_jump;
    logic              reg_wrenable;
    logic [REG_W-1:0]  write_reg;
    logic              mem_wrenable;
    logic              mem_to_reg;
  } exmem_t;

  // Register x0 is hard-wired, so it never counts as a real destination.
  function automatic logic reg_nonzero(input logic [REG_W-1:0] r);
    return (r != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_dmem_if.sv
// Data-memory access controller: tracks wait states of an outstanding
// request and derives req/we/addr/wdata, the qualified ack and the stall.
module mem_dmem_if
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_mem_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  mem_stage_if.master       dmem
);

  dmem_state_e state_q;
  dmem_state_e state_d;
  logic        req_s;

  // Access FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The request is raised straight from the latch so a zero-wait memory
  // can complete in the first cycle without ever entering ACCESS.
  always_comb begin
    state_d = state_q;
    req_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_s = is_mem_i;
        if (is_mem_i && !dmem.dmem_ack) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        req_s = is_mem_i;
        if (dmem.dmem_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        req_s   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs, qualified ack and stall.
  always_comb begin
    dmem.dmem_req   = req_s;
    dmem.dmem_we    = req_s & mem_we_i;
    dmem.dmem_addr  = req_s ? addr_i  : {ADDR_W{1'b0}};
    dmem.dmem_wdata = req_s ? wdata_i : {DATA_W{1'b0}};
    ack_o           = req_s & dmem.dmem_ack;
    rdata_o         = dmem.dmem_rdata;
    stall_o         = req_s & ~dmem.dmem_ack;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM latch, data-memory access via mem_dmem_if,
// MEM/WB register and the forwarding path back to execute.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic              is_jump_i,
  input  logic              reg_wrenable_i,
  input  logic [REG_W-1:0]  write_reg_i,
  input  logic              mem_wrenable_i,
  input  logic              mem_to_reg_i,
  output logic              stall_o,
  mem_stage_if.master       dmem,
  output logic              wb_valid_o,
  output logic              wb_reg_wrenable_o,
  output logic [REG_W-1:0]  wb_write_reg_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [DATA_W-1:0] fwd_res_o,
  output logic [REG_W-1:0]  fwd_reg_o,
  output logic              fwd_valid_o
);

  exmem_t            ex_q;
  exmem_t            ex_d;
  logic              mem_valid_q;
  logic              mem_valid_d;

  logic              wb_valid_q;
  logic              wb_valid_d;
  logic              wb_reg_wrenable_q;
  logic              wb_reg_wrenable_d;
  logic [REG_W-1:0]  wb_write_reg_q;
  logic [REG_W-1:0]  wb_write_reg_d;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] wb_data_d;

  logic              is_mem_s;
  logic              is_load_s;
  logic              stall_s;
  logic              ack_s;
  logic [DATA_W-1:0] rdata_s;

  // Latched instruction decode; a store overrides mem_to_reg.
  always_comb begin
    is_mem_s  = mem_valid_q & (ex_q.mem_wrenable | ex_q.mem_to_reg);
    is_load_s = mem_valid_q & ex_q.mem_to_reg & ~ex_q.mem_wrenable;
  end

  mem_dmem_if u_dmem_if (
    .clk      (clk),
    .rst_n    (rst_n),
    .is_mem_i (is_mem_s),
    .mem_we_i (ex_q.mem_wrenable),
    .addr_i   (ex_q.alu_res[ADDR_W-1:0]),
    .wdata_i  (ex_q.write_data),
    .ack_o    (ack_s),
    .rdata_o  (rdata_s),
    .stall_o  (stall_s),
    .dmem     (dmem)
  );

  // EX/MEM next state: capture when not stalled, otherwise hold.
  always_comb begin
    ex_d        = ex_q;
    mem_valid_d = mem_valid_q;
    if (!stall_s) begin
      ex_d.alu_res      = alu_res_i;
      ex_d.write_data   = write_data_i;
      ex_d.is_jump      = is_jump_i;
      ex_d.reg_wrenable = reg_wrenable_i;
      ex_d.write_reg    = write_reg_i;
      ex_d.mem_wrenable = mem_wrenable_i;
      ex_d.mem_to_reg   = mem_to_reg_i;
      mem_valid_d       = in_valid_i;
    end else begin
      ex_d        = ex_q;
      mem_valid_d = mem_valid_q;
    end
  end

  // MEM/WB next state: a stall retires nothing, so a bubble is inserted.
  always_comb begin
    wb_valid_d        = wb_valid_q;
    wb_reg_wrenable_d = wb_reg_wrenable_q;
    wb_write_reg_d    = wb_write_reg_q;
    wb_data_d         = wb_data_q;
    if (!stall_s) begin
      wb_valid_d        = mem_valid_q;
      wb_reg_wrenable_d = mem_valid_q & ex_q.reg_wrenable &
                          reg_nonzero(ex_q.write_reg) & ~ex_q.mem_wrenable;
      wb_write_reg_d    = ex_q.write_reg;
      if (is_load_s && ack_s) begin
        wb_data_d = rdata_s;
      end else if (ex_q.is_jump) begin
        wb_data_d = ex_q.write_data;
      end else begin
        wb_data_d = ex_q.alu_res;
      end
    end else begin
      wb_valid_d        = 1'b0;
      wb_reg_wrenable_d = 1'b0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q              <= '0;
      mem_valid_q       <= 1'b0;
      wb_valid_q        <= 1'b0;
      wb_reg_wrenable_q <= 1'b0;
      wb_write_reg_q    <= {REG_W{1'b0}};
      wb_data_q         <= {DATA_W{1'b0}};
    end else begin
      ex_q              <= ex_d;
      mem_valid_q       <= mem_valid_d;
      wb_valid_q        <= wb_valid_d;
      wb_reg_wrenable_q <= wb_reg_wrenable_d;
      wb_write_reg_q    <= wb_write_reg_d;
      wb_data_q         <= wb_data_d;
    end
  end

  // Output drive; loads are never forwarded from this stage.
  always_comb begin
    stall_o           = stall_s;
    wb_valid_o        = wb_valid_q;
    wb_reg_wrenable_o = wb_reg_wrenable_q;
    wb_write_reg_o    = wb_write_reg_q;
    wb_data_o         = wb_data_q;
    fwd_res_o         = ex_q.is_jump ? ex_q.write_data : ex_q.alu_res;
    fwd_reg_o         = ex_q.write_reg;
    fwd_valid_o       = mem_valid_q & ex_q.reg_wrenable & ~ex_q.mem_to_reg &
                        reg_nonzero(ex_q.write_reg);
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against an instruction-level reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    bit          v;
    logic [31:0] alu;
    logic [31:0] wd;
    bit          jmp;
    bit          rwe;
    logic [4:0]  wr;
    bit          mwe;
    bit          m2r;
    int          nwait;
    logic [31:0] rdata;
  } ins_t;

  typedef struct {
    bit          v;
    bit          we;
    logic [4:0]  wr;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, is_jump, reg_wrenable, mem_wrenable, mem_to_reg;
  logic [31:0] alu_res, write_data;
  logic [4:0]  write_reg;
  logic        stall, wb_valid, wb_reg_wrenable, fwd_valid;
  logic [4:0]  wb_write_reg, fwd_reg;
  logic [31:0] wb_data, fwd_res;

  int n_vec = 0;
  int n_err = 0;

  ins_t cur;
  wb_t  wbm;
  int   waited;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid_i        (in_valid),
    .alu_res_i         (alu_res),
    .write_data_i      (write_data),
    .is_jump_i         (is_jump),
    .reg_wrenable_i    (reg_wrenable),
    .write_reg_i       (write_reg),
    .mem_wrenable_i    (mem_wrenable),
    .mem_to_reg_i      (mem_to_reg),
    .stall_o           (stall),
    .dmem              (dmem),
    .wb_valid_o        (wb_valid),
    .wb_reg_wrenable_o (wb_reg_wrenable),
    .wb_write_reg_o    (wb_write_reg),
    .wb_data_o         (wb_data),
    .fwd_res_o         (fwd_res),
    .fwd_reg_o         (fwd_reg),
    .fwd_valid_o       (fwd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic ins_t mk(bit v, logic [31:0] alu, logic [31:0] wd, bit jmp, bit rwe,
                              logic [4:0] wr, bit mwe, bit m2r, int nwait, logic [31:0] rdata);
    ins_t x;
    x.v = v; x.alu = alu; x.wd = wd; x.jmp = jmp; x.rwe = rwe; x.wr = wr;
    x.mwe = mwe; x.m2r = m2r; x.nwait = nwait; x.rdata = rdata;
    return x;
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    int   kind;
    kind = $urandom_range(0, 6);
    x = mk(1'b1, $urandom(), $urandom(), 1'b0, 1'b1, 5'($urandom_range(1, 31)),
           1'b0, 1'b0, $urandom_range(0, 3), $urandom());
    case (kind)
      1: x.m2r = 1'b1;
      2: begin x.mwe = 1'b1; x.rwe = 1'($urandom_range(0, 1)); x.m2r = 1'($urandom_range(0, 1)); end
      3: x.jmp = 1'b1;
      4: begin x.v = 1'b0; x.mwe = 1'($urandom_range(0, 1)); end
      5: x.wr = 5'd0;
      6: x.rwe = 1'b0;
      default: ;
    endcase
    return x;
  endfunction

  task automatic drive_ins(input ins_t x);
    in_valid     = x.v;
    alu_res      = x.alu;
    write_data   = x.wd;
    is_jump      = x.jmp;
    reg_wrenable = x.rwe;
    write_reg    = x.wr;
    mem_wrenable = x.mwe;
    mem_to_reg   = x.m2r;
  endtask

  task automatic model_reset();
    cur    = mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 32'd0);
    wbm    = '{v: 1'b0, we: 1'b0, wr: 5'd0, data: 32'd0};
    waited = 0;
  endtask

  // One cycle, entered and left on a falling edge.
  task automatic step(input ins_t nxt, output bit took);
    bit is_mem, ack, exp_stall;
    is_mem = cur.v && (cur.mwe || cur.m2r);
    if (is_mem) ack = (waited >= cur.nwait);
    else        ack = 1'($urandom_range(0, 1));
    dmem.dmem_ack   = ack;
    dmem.dmem_rdata = is_mem ? cur.rdata : $urandom();
    #1;
    exp_stall = is_mem && !ack;
    chk("stall", stall, exp_stall);
    chk("dmem_req", dmem.dmem_req, is_mem);
    if (is_mem) begin
      chk("dmem_we", dmem.dmem_we, cur.mwe);
      chk("dmem_addr", dmem.dmem_addr, cur.alu % 256);
      chk("dmem_wdata", dmem.dmem_wdata, cur.wd);
    end
    chk("fwd_res", fwd_res, cur.jmp ? cur.wd : cur.alu);
    chk("fwd_reg", fwd_reg, cur.wr);
    chk("fwd_valid", fwd_valid, cur.v && cur.rwe && !cur.m2r && (cur.wr != 5'd0));
    chk("wb_valid", wb_valid, wbm.v);
    chk("wb_reg_wrenable", wb_reg_wrenable, wbm.we);
    if (wbm.v) begin
      chk("wb_write_reg", wb_write_reg, wbm.wr);
      chk("wb_data", wb_data, wbm.data);
    end
    if (exp_stall) begin
      drive_ins(rand_ins());
      wbm.v  = 1'b0;
      wbm.we = 1'b0;
      waited++;
    end else begin
      drive_ins(nxt);
      wbm.v  = cur.v;
      wbm.wr = cur.wr;
      wbm.we = cur.v && cur.rwe && (cur.wr != 5'd0) && !cur.mwe;
      if (cur.v && cur.m2r && !cur.mwe) wbm.data = cur.rdata;
      else if (cur.jmp)                 wbm.data = cur.wd;
      else                              wbm.data = cur.alu;
      cur    = nxt;
      waited = 0;
    end
    took = !exp_stall;
    @(negedge clk);
  endtask

  task automatic issue(input ins_t x);
    bit took;
    took = 1'b0;
    for (int t = 0; t < 12 && !took; t++) step(x, took);
    if (!took) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    ins_t dir[$];
    bit   took;
    model_reset();
    drive_ins(cur);
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", dmem.dmem_req, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    chk("rst_fwd_res", fwd_res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dir.push_back(mk(1, 32'h1234, 32'h0, 0, 1, 5'd3, 0, 0, 0, 32'h0));
    dir.push_back(mk(1, 32'h05, 32'hDEAD, 0, 0, 5'd0, 1, 0, 2, 32'h0));
    dir.push_back(mk(1, 32'h10, 32'h0, 0, 1, 5'd7, 0, 1, 0, 32'hCAFE));
    dir.push_back(mk(1, 32'h99, 32'h0A, 1, 1, 5'd1, 0, 0, 0, 32'h0));
    dir.push_back(mk(1, 32'h55, 32'h0, 0, 1, 5'd0, 0, 0, 0, 32'h0));
    dir.push_back(mk(1, 32'hFFFF_FF21, 32'h77, 0, 1, 5'd9, 0, 1, 3, 32'h1357));
    dir.push_back(mk(1, 32'h22, 32'h88, 0, 0, 5'd2, 1, 0, 0, 32'h0));
    dir.push_back(mk(0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0, 0, 32'h0));
    foreach (dir[i]) issue(dir[i]);
    for (int i = 0; i < 250; i++) issue(rand_ins());

    // Reset while a store waits for an ack that never comes.
    issue(mk(1, 32'h05, 32'hBEEF, 0, 0, 5'd0, 1, 0, 1000, 32'h0));
    step(mk(0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0, 0, 32'h0), took);
    step(mk(0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0, 0, 32'h0), took);
    @(posedge clk);
    #2;
    chk("pre_rst_req", dmem.dmem_req, 1'b1);
    chk("pre_rst_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", dmem.dmem_req, 1'b0);
    chk("async_rst_stall", stall, 1'b0);
    chk("async_rst_wb_valid", wb_valid, 1'b0);
    chk("async_rst_fwd_valid", fwd_valid, 1'b0);
    @(negedge clk);
    model_reset();
    drive_ins(cur);
    dmem.dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(1, 32'h4321, 32'h0, 0, 1, 5'd4, 0, 0, 0, 32'h0));
    for (int i = 0; i < 40; i++) issue(rand_ins());
    for (int i = 0; i < 3; i++) issue(mk(0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0, 0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
